// File: rtl/cbus_rr_arbiter.sv
// cbus_pkg / cbus_rr_arbiter
//
// Purpose: N-to-1 arbiter from the cache/uncached masters onto the single
// memory-side cbus. It supports rotating or fixed priority and can forward
// the winner in the same cycle it is selected. A grant is held from the
// first request beat until oresp.last of the granted master. An optional
// watchdog releases a grant whose slave has stopped answering.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-low
//   ireqs        per-master requests; only .valid is examined
//   iresps       per-master responses; only the granted master sees oresp
//   oreq         request forwarded to the memory side
//   oresp        memory response; .ready and .last drive the FSM
//   busy         a grant is held (BUSY state)
//   grant_idx    current or same-cycle forwarded winner
//   timeout_err  one-cycle pulse when the watchdog releases a grant
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant held; arbitrate (and optionally forward) a winner
// BUSY  | grant held by grant_q until oresp.last or watchdog expiry

package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;
endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int ROUND_ROBIN = 1,
  parameter int FAST_GRANT  = 1,
  parameter int TIMEOUT     = 0,
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0] iresps,
  output cbus_req_t                   oreq,
  input  cbus_resp_t                  oresp,
  output logic                        busy,
  output logic [IW-1:0]               grant_idx,
  output logic                        timeout_err
);

  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t          state;
  logic            busy_q;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   rr_ptr;
  logic [WW-1:0]   wdog;

  logic            win_valid;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;

  logic            beat_last;
  logic            wdog_fire;

  // Candidates are scanned from lowest to highest priority so that the
  // last hit, i.e. the highest-priority valid input, is the one kept.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (ROUND_ROBIN != 0) begin
      for (int k = NUM_INPUTS; k >= 1; k--) begin
        cand = IW'((int'(rr_ptr) + k) % NUM_INPUTS);
        if (ireqs[cand].valid) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end else begin
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        cand = IW'(i);
        if (ireqs[cand].valid) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  assign beat_last = oresp.ready && oresp.last;
  // Release on last takes precedence over the watchdog because the
  // release branch is tested first in the FSM.
  assign wdog_fire = (TIMEOUT > 0) && !oresp.ready && (wdog == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      rr_ptr      <= IW'(NUM_INPUTS - 1);
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          wdog <= '0;
          if (win_valid) begin
            grant_q <= win_idx;
            if ((FAST_GRANT != 0) && beat_last) begin
              // Single-beat transfer finished during the pass-through cycle.
              if (ROUND_ROBIN != 0) rr_ptr <= win_idx;
            end else begin
              state  <= ST_BUSY;
              busy_q <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (beat_last) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            wdog   <= '0;
            if (ROUND_ROBIN != 0) rr_ptr <= grant_q;
          end else if (wdog_fire) begin
            state       <= ST_IDLE;
            busy_q      <= 1'b0;
            wdog        <= '0;
            timeout_err <= 1'b1;
            if (ROUND_ROBIN != 0) rr_ptr <= grant_q;
          end else if (oresp.ready) begin
            wdog <= '0;
          end else if (TIMEOUT > 0) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Reset low blanks the bus in the same cycle, abandoning any burst.
  always_comb begin
    oreq      = '0;
    iresps    = '0;
    grant_idx = '0;
    if (reset) begin
      grant_idx = grant_q;
      if (state == ST_BUSY) begin
        oreq            = ireqs[grant_q];
        iresps[grant_q] = oresp;
      end else if ((FAST_GRANT != 0) && win_valid) begin
        oreq            = ireqs[win_idx];
        iresps[win_idx] = oresp;
        grant_idx       = win_idx;
      end
    end
  end

  assign busy = busy_q & reset;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Testbench for cbus_rr_arbiter. Three instances are used:
//   a: round-robin, fast grant, TIMEOUT=8
//   b: fixed priority, fast grant, no watchdog
//   c: round-robin, registered grant, no watchdog

module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  logic clk;
  logic reset;

  cbus_req_t  [3:0] a_ireqs, b_ireqs, c_ireqs;
  cbus_resp_t [3:0] a_iresps, b_iresps, c_iresps;
  cbus_req_t        a_oreq, b_oreq, c_oreq;
  cbus_resp_t       a_oresp, b_oresp, c_oresp;
  logic             a_busy, b_busy, c_busy;
  logic [1:0]       a_gidx, b_gidx, c_gidx;
  logic             a_terr, b_terr, c_terr;

  int n_vec = 0;
  int n_err = 0;

  cbus_rr_arbiter #(.NUM_INPUTS(4), .ROUND_ROBIN(1), .FAST_GRANT(1), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .ireqs(a_ireqs), .iresps(a_iresps), .oreq(a_oreq),
    .oresp(a_oresp), .busy(a_busy), .grant_idx(a_gidx), .timeout_err(a_terr));

  cbus_rr_arbiter #(.NUM_INPUTS(4), .ROUND_ROBIN(0), .FAST_GRANT(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .ireqs(b_ireqs), .iresps(b_iresps), .oreq(b_oreq),
    .oresp(b_oresp), .busy(b_busy), .grant_idx(b_gidx), .timeout_err(b_terr));

  cbus_rr_arbiter #(.NUM_INPUTS(4), .ROUND_ROBIN(1), .FAST_GRANT(0), .TIMEOUT(0)) dut_c (
    .clk(clk), .reset(reset), .ireqs(c_ireqs), .iresps(c_iresps), .oreq(c_oreq),
    .oresp(c_oresp), .busy(c_busy), .grant_idx(c_gidx), .timeout_err(c_terr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cbus_req_t mk_req(input int i, input logic v);
    cbus_req_t r;
    r          = '0;
    r.valid    = v;
    r.is_write = i[0];
    r.addr     = 32'h1000_0000 + 32'(i) * 32'h100;
    r.wdata    = 32'hA5A5_0000 | 32'(i);
    r.strb     = 4'hF;
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [31:0] d);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.rdata = d;
    return r;
  endfunction

  // g < 0 means no grant visible: oreq and every iresps must be zero.
  task automatic chk_port(input string tag, input cbus_req_t [3:0] rq, input cbus_resp_t rs,
                          input cbus_req_t oq, input cbus_resp_t [3:0] irs, input logic bz,
                          input logic [1:0] gx, input logic te, input int g,
                          input logic exp_busy, input logic exp_terr);
    cbus_req_t  er;
    cbus_resp_t ers;
    logic [1:0] ii;
    er = '0;
    if (g >= 0) er = rq[g[1:0]];
    check({tag, ".oreq"}, 96'(oq), 96'(er));
    for (int i = 0; i < 4; i++) begin
      ii  = 2'(i);
      ers = (i == g) ? rs : '0;
      check($sformatf("%s.iresps[%0d]", tag, i), 96'(irs[ii]), 96'(ers));
    end
    if (g >= 0) check({tag, ".grant_idx"}, 96'(gx), 96'(g[1:0]));
    check({tag, ".busy"}, 96'(bz), 96'(exp_busy));
    check({tag, ".timeout_err"}, 96'(te), 96'(exp_terr));
  endtask

  task automatic chk_a(input string tag, input int g, input logic eb, input logic et);
    chk_port(tag, a_ireqs, a_oresp, a_oreq, a_iresps, a_busy, a_gidx, a_terr, g, eb, et);
  endtask

  task automatic chk_b(input string tag, input int g, input logic eb);
    chk_port(tag, b_ireqs, b_oresp, b_oreq, b_iresps, b_busy, b_gidx, b_terr, g, eb, 1'b0);
  endtask

  task automatic chk_c(input string tag, input int g, input logic eb);
    chk_port(tag, c_ireqs, c_oresp, c_oreq, c_iresps, c_busy, c_gidx, c_terr, g, eb, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_ireqs[i] = mk_req(i, 1'b1);
      b_ireqs[i] = mk_req(i, 1'b0);
      c_ireqs[i] = mk_req(i, 1'b0);
    end
    a_oresp = mk_resp(1'b1, 1'b1, 32'hDEAD_0000);
    b_oresp = '0;
    c_oresp = '0;

    // Reset held low for two edges with every master of a requesting.
    #1;
    check("rst0.oreq", 96'(a_oreq), 96'(0));
    check("rst0.grant_idx", 96'(a_gidx), 96'(0));
    tick();
    chk_a("rst1", -1, 1'b0, 1'b0);
    check("rst1.grant_idx", 96'(a_gidx), 96'(0));
    tick();
    chk_a("rst2", -1, 1'b0, 1'b0);
    check("rst2.grant_idx", 96'(a_gidx), 96'(0));
    reset = 1'b1;

    // Single-beat back-to-back transfers: grants rotate 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      a_oresp = mk_resp(1'b1, 1'b1, 32'hD000_0000 | 32'(k));
      #1;
      chk_a($sformatf("rr1beat%0d", k), k % 4, 1'b0, 1'b0);
      tick();
    end

    // Hung slave: master 1 forwarded, then 8 BUSY cycles without ready.
    a_oresp = mk_resp(1'b0, 1'b0, 32'hBAD0_0001);
    #1;
    chk_a("hang.grant", 1, 1'b0, 1'b0);
    tick();
    for (int b = 1; b <= 8; b++) begin
      #1;
      chk_a($sformatf("hang.busy%0d", b), 1, 1'b1, 1'b0);
      tick();
    end
    // Watchdog fired: pulse now, and master 2 is forwarded instead of 1.
    #1;
    chk_a("hang.expire", 2, 1'b0, 1'b1);
    tick();
    // Seven silent beats, then ready+last on the beat the watchdog would fire.
    for (int b = 1; b <= 7; b++) begin
      #1;
      chk_a($sformatf("race.busy%0d", b), 2, 1'b1, 1'b0);
      tick();
    end
    a_oresp = mk_resp(1'b1, 1'b1, 32'hC0DE_0008);
    #1;
    chk_a("race.last", 2, 1'b1, 1'b0);
    tick();
    a_oresp = mk_resp(1'b0, 1'b0, 32'h0);
    #1;
    chk_a("race.after", 3, 1'b0, 1'b0);
    tick();
    // Granted master drops valid mid-burst: grant is kept, oreq mirrors it.
    a_ireqs[3] = mk_req(3, 1'b0);
    #1;
    chk_a("drop.valid", 3, 1'b1, 1'b0);
    tick();
    // Reset mid-burst while the slave returns last: nothing reaches master 3.
    reset   = 1'b0;
    a_oresp = mk_resp(1'b1, 1'b1, 32'h5555_0003);
    #1;
    chk_a("midrst.during", -1, 1'b0, 1'b0);
    tick();
    chk_a("midrst.after", -1, 1'b0, 1'b0);
    reset      = 1'b1;
    a_ireqs[3] = mk_req(3, 1'b1);
    #1;
    chk_a("midrst.regrant", 0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) a_ireqs[i] = mk_req(i, 1'b0);
    a_oresp = '0;
    #1;
    chk_a("a.idle", -1, 1'b0, 1'b0);

    // Fixed priority: 4-beat burst on master 1 while master 3 waits.
    b_ireqs[1] = mk_req(1, 1'b1);
    b_ireqs[3] = mk_req(3, 1'b1);
    b_oresp    = mk_resp(1'b1, 1'b0, 32'hB000_0001);
    #1;
    chk_b("fix.beat1", 1, 1'b0);
    tick();
    b_oresp = mk_resp(1'b1, 1'b0, 32'hB000_0002);
    #1;
    chk_b("fix.beat2", 1, 1'b1);
    tick();
    b_ireqs[0] = mk_req(0, 1'b1);
    b_oresp    = mk_resp(1'b1, 1'b0, 32'hB000_0003);
    #1;
    chk_b("fix.beat3", 1, 1'b1);
    tick();
    b_ireqs[0] = mk_req(0, 1'b0);
    b_oresp    = mk_resp(1'b1, 1'b1, 32'hB000_0004);
    #1;
    chk_b("fix.beat4", 1, 1'b1);
    tick();
    b_ireqs[1] = mk_req(1, 1'b0);
    b_oresp    = mk_resp(1'b1, 1'b1, 32'hB000_0005);
    #1;
    chk_b("fix.next", 3, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) b_ireqs[i] = mk_req(i, 1'b0);
    b_oresp = '0;

    // Registered grant: nothing forwarded in the selection cycle.
    c_ireqs[2] = mk_req(2, 1'b1);
    c_oresp    = mk_resp(1'b1, 1'b1, 32'hC000_0002);
    #1;
    chk_c("slow.sel", -1, 1'b0);
    tick();
    #1;
    chk_c("slow.busy", 2, 1'b1);
    tick();
    // Pointer now at 2: with 2 and 3 requesting, 3 must win.
    c_ireqs[3] = mk_req(3, 1'b1);
    c_oresp    = mk_resp(1'b0, 1'b0, 32'h0);
    #1;
    chk_c("slow.sel2", -1, 1'b0);
    tick();
    c_oresp = mk_resp(1'b1, 1'b1, 32'hC000_0003);
    #1;
    chk_c("slow.busy2", 3, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) c_ireqs[i] = mk_req(i, 1'b0);
    c_oresp = '0;
    #1;
    chk_c("slow.idle", -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
